// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl
// Front-end sequencer for systolic_array. On an accepted start it latches the
// A and B operand matrices, pulses sa_start_o for one cycle, and then streams
// the operands as a diagonal wavefront. Row r of A and column c of B are
// delayed by r and c cycles respectively. It then waits for the array's finish
// and emits a single done pulse.
// Optional feature: define SA_FEED_TIMEOUT_EN to add a DRAIN watchdog.
// The watchdog raises a sticky timeout_o and forces DONE after TIMEOUT_CYCLES
// DRAIN cycles that see no finish.
module systolic_feed_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int BUS_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic flush_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0] a_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0] b_i,
  input  logic sa_finish_i,
  output logic sa_start_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0] left_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0] up_o,
  output logic busy_o,
  output logic done_o,
  output logic timeout_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int MAT_W   = MAX_DIM * MAX_DIM * DATA_WIDTH;
  localparam int VEC_W   = MAX_DIM * DATA_WIDTH;
  localparam int CW      = $clog2(2 * MAX_DIM);
  localparam logic [CW-1:0] LAST_STEP = CW'(2 * MAX_DIM - 2);
  localparam logic [CW-1:0] STEP_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] STEP_ONE  = CW'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e            state_q;
  logic [MAT_W-1:0]  a_q;
  logic [MAT_W-1:0]  b_q;
  logic [CW-1:0]     t_q;
  logic              fin_q;
  logic              sa_start_q;
  logic              busy_q;
  logic              done_q;
  logic [VEC_W-1:0]  left_q;
  logic [VEC_W-1:0]  up_q;

`ifdef SA_FEED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] drain_cnt_q;
  logic          timeout_q;
`endif

  // Left-bus wavefront at step t: row r carries A[r][t-r] when that column exists.
  function automatic logic [VEC_W-1:0] skew_left(input logic [MAT_W-1:0] m,
                                                 input logic [CW-1:0]    t);
    logic [VEC_W-1:0] v;
    int k;
    v = '0;
    for (int r = 0; r < MAX_DIM; r++) begin
      k = int'(t) - r;
      if (k >= 0 && k < MAX_DIM) begin
        v[r*DATA_WIDTH +: DATA_WIDTH] = m[(r*MAX_DIM + k)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        v[r*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
    return v;
  endfunction

  // Up-bus wavefront at step t: column c carries B[t-c][c] when that row exists.
  function automatic logic [VEC_W-1:0] skew_up(input logic [MAT_W-1:0] m,
                                               input logic [CW-1:0]    t);
    logic [VEC_W-1:0] v;
    int k;
    v = '0;
    for (int c = 0; c < MAX_DIM; c++) begin
      k = int'(t) - c;
      if (k >= 0 && k < MAX_DIM) begin
        v[c*DATA_WIDTH +: DATA_WIDTH] = m[(k*MAX_DIM + c)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        v[c*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
    return v;
  endfunction

  // Sequencer FSM with registered outputs: each output register holds the value for the state being entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      t_q        <= '0;
      fin_q      <= 1'b0;
      sa_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      left_q     <= '0;
      up_q       <= '0;
`ifdef SA_FEED_TIMEOUT_EN
      drain_cnt_q <= '0;
      timeout_q   <= 1'b0;
`endif
    end else if (flush_i) begin
      // Abort: drop operands and outputs; the timeout flag is left for software to read.
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      t_q        <= '0;
      fin_q      <= 1'b0;
      sa_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      left_q     <= '0;
      up_q       <= '0;
`ifdef SA_FEED_TIMEOUT_EN
      drain_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_q        <= a_i;
            b_q        <= b_i;
            t_q        <= '0;
            fin_q      <= 1'b0;
            sa_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_LAUNCH;
`ifdef SA_FEED_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
          end else begin
            sa_start_q <= 1'b0;
            busy_q     <= 1'b0;
          end
          done_q <= 1'b0;
          left_q <= '0;
          up_q   <= '0;
        end

        S_LAUNCH: begin
          sa_start_q <= 1'b0;
          t_q        <= '0;
          fin_q      <= fin_q | sa_finish_i;
          left_q     <= skew_left(a_q, STEP_ZERO);
          up_q       <= skew_up(b_q, STEP_ZERO);
          state_q    <= S_FEED;
        end

        S_FEED: begin
          fin_q <= fin_q | sa_finish_i;
          if (t_q == LAST_STEP) begin
            left_q  <= '0;
            up_q    <= '0;
            state_q <= S_DRAIN;
`ifdef SA_FEED_TIMEOUT_EN
            drain_cnt_q <= '0;
`endif
          end else begin
            t_q    <= t_q + STEP_ONE;
            left_q <= skew_left(a_q, t_q + STEP_ONE);
            up_q   <= skew_up(b_q, t_q + STEP_ONE);
          end
        end

        S_DRAIN: begin
          left_q <= '0;
          up_q   <= '0;
          if (sa_finish_i || fin_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef SA_FEED_TIMEOUT_EN
          end else if (drain_cnt_q == LAST_CNT) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            drain_cnt_q <= drain_cnt_q + TW'(1'b1);
`else
          end else begin
            state_q <= S_DRAIN;
`endif
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          fin_q   <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q    <= S_IDLE;
          sa_start_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          left_q     <= '0;
          up_q       <= '0;
        end
      endcase
    end
  end

  assign sa_start_o = sa_start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign left_o     = left_q;
  assign up_o       = up_q;

`ifdef SA_FEED_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  // Watchdog compiled out: the flag never rises for any legal TIMEOUT_CYCLES.
  assign timeout_o = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl (MAX_DIM = 4).
// Stimulus pushes one expected record per busy cycle; a negedge monitor pops and compares.
module tb_systolic_feed_ctrl;

  localparam int DW = 16;
  localparam int MD = 4;

  typedef logic [MD*MD*DW-1:0] mat_t;
  typedef logic [MD*DW-1:0]    vec_t;
  typedef struct packed {
    logic sa_start;
    logic done;
    vec_t left;
    vec_t up;
  } rec_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic start_i = 1'b0;
  logic flush_i = 1'b0;
  mat_t a_i = '0;
  mat_t b_i = '0;
  logic sa_finish_i = 1'b0;
  logic sa_start_o;
  vec_t left_o;
  vec_t up_o;
  logic busy_o;
  logic done_o;
  logic timeout_o;

  int n_checks = 0;
  int n_errors = 0;
  rec_t exp_q[$];

  systolic_feed_ctrl #(.DATA_WIDTH(16), .BUS_WIDTH(64), .TIMEOUT_CYCLES(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .flush_i(flush_i),
    .a_i(a_i), .b_i(b_i), .sa_finish_i(sa_finish_i), .sa_start_o(sa_start_o),
    .left_o(left_o), .up_o(up_o), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bench-side wavefront model: element (r,k) of A sits on row r at step r+k.
  function automatic vec_t model_left(input mat_t a, input int t);
    vec_t v = '0;
    for (int r = 0; r < MD; r++)
      for (int k = 0; k < MD; k++)
        if (r + k == t) v[r*DW +: DW] = a[(r*MD + k)*DW +: DW];
    return v;
  endfunction

  // Element (k,c) of B sits on column c at step k+c.
  function automatic vec_t model_up(input mat_t b, input int t);
    vec_t v = '0;
    for (int k = 0; k < MD; k++)
      for (int c = 0; c < MD; c++)
        if (k + c == t) v[c*DW +: DW] = b[(k*MD + c)*DW +: DW];
    return v;
  endfunction

  task automatic push(input logic s, input logic d, input vec_t l, input vec_t u);
    rec_t r;
    r.sa_start = s; r.done = d; r.left = l; r.up = u;
    exp_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each busy cycle must match the next expected record; idle cycles must be quiet.
  always @(negedge clk) begin
    rec_t e;
    if (rst_ni) begin
      if (busy_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_busy", 256'(busy_o), 256'(1'b0));
        end else begin
          e = exp_q.pop_front();
          check("sa_start", 256'(sa_start_o), 256'(e.sa_start));
          check("done",     256'(done_o),     256'(e.done));
          check("left",     256'(left_o),     256'(e.left));
          check("up",       256'(up_o),       256'(e.up));
        end
      end else begin
        check("idle_quiet", 256'({sa_start_o, done_o, left_o, up_o}), 256'(0));
      end
    end
  end

  // One full operation; fin_at is the cycle index after the start edge during which sa_finish_i is high.
  task automatic run_op(input mat_t a, input mat_t b, input int fin_at,
                        input bit hold, input bit hand);
    int drain_n;
    vec_t l, u;
    drain_n = (fin_at < 8) ? 1 : fin_at - 7;
    push(1'b1, 1'b0, '0, '0);
    for (int t = 0; t < 7; t++) begin
      l = model_left(a, t);
      u = model_up(b, t);
      if (hand && t == 0) begin l = 64'h0000_0000_0000_0001; u = 64'h0000_0000_0000_0080; end
      if (hand && t == 3) begin l = 64'h0031_0022_0013_0004; u = 64'h0083_0092_00A1_00B0; end
      push(1'b0, 1'b0, l, u);
    end
    for (int j = 0; j < drain_n; j++) push(1'b0, 1'b0, '0, '0);
    push(1'b0, 1'b1, '0, '0);
    a_i = a; b_i = b; start_i = 1'b1;
    tick();
    for (int i = 0; i <= 8 + drain_n; i++) begin
      sa_finish_i = (i == fin_at);
      if (hold) begin a_i = ~a_i; b_i = ~b_i; end
      else start_i = 1'b0;
      tick();
    end
    sa_finish_i = 1'b0;
    check("idle_after_op", 256'({busy_o, done_o}), 256'(0));
  endtask

  mat_t ma, mb, mi;

  initial begin
    for (int r = 0; r < MD; r++)
      for (int k = 0; k < MD; k++) begin
        ma[(r*MD + k)*DW +: DW] = 16'(16*r + k + 1);
        mb[(r*MD + k)*DW +: DW] = 16'(16*r + k + 'h80);
        mi[(r*MD + k)*DW +: DW] = (r == k) ? 16'h0001 : 16'h0000;
      end

    tick(); tick();
    check("reset_outputs", 256'({sa_start_o, busy_o, done_o, timeout_o, left_o, up_o}), 256'(0));
    rst_ni = 1'b1;
    tick();

    // Skew pattern with hand-computed wavefront at t=0 and t=3; finish arrives in DRAIN.
    run_op(ma, mb, 10, 1'b0, 1'b1);
    // Identity A, arbitrary B; finish seen during FEED so DRAIN lasts one cycle.
    run_op(mi, mb, 4, 1'b0, 1'b0);
    // Finish during LAUNCH.
    run_op(mb, ma, 0, 1'b0, 1'b0);
    // start_i held with changing operands: one op using the first capture, then a restart.
    run_op(ma, mi, 8, 1'b1, 1'b0);
    run_op(mb, mb, 9, 1'b0, 1'b0);

    // Flush at FEED t=2.
    push(1'b1, 1'b0, '0, '0);
    for (int t = 0; t < 3; t++) push(1'b0, 1'b0, model_left(ma, t), model_up(mb, t));
    a_i = ma; b_i = mb; start_i = 1'b1;
    tick(); start_i = 1'b0;
    tick(); tick(); tick();
    flush_i = 1'b1;
    tick(); flush_i = 1'b0;
    check("flush_idle", 256'({busy_o, done_o, left_o, up_o}), 256'(0));
    // Flush beats start in IDLE.
    flush_i = 1'b1; start_i = 1'b1;
    tick(); flush_i = 1'b0; start_i = 1'b0;
    check("flush_over_start", 256'(busy_o), 256'(0));
    tick();

    // Async reset at FEED t=3.
    push(1'b1, 1'b0, '0, '0);
    for (int t = 0; t < 4; t++) push(1'b0, 1'b0, model_left(mb, t), model_up(ma, t));
    a_i = mb; b_i = ma; start_i = 1'b1;
    tick(); start_i = 1'b0;
    tick(); tick(); tick(); tick();
    #6 rst_ni = 1'b0;
    #1 check("async_reset", 256'({sa_start_o, busy_o, done_o, left_o, up_o}), 256'(0));
    tick(); rst_ni = 1'b1;
    tick();
    check("idle_after_reset", 256'(busy_o), 256'(0));

    // No finish at all: watchdog behaviour.
    push(1'b1, 1'b0, '0, '0);
    for (int t = 0; t < 7; t++) push(1'b0, 1'b0, model_left(ma, t), model_up(mb, t));
`ifdef SA_FEED_TIMEOUT_EN
    for (int j = 0; j < 32; j++) push(1'b0, 1'b0, '0, '0);
    push(1'b0, 1'b1, '0, '0);
    a_i = ma; b_i = mb; start_i = 1'b1;
    tick(); start_i = 1'b0;
    for (int i = 0; i < 41; i++) tick();
    check("timeout_flag", 256'({timeout_o, busy_o}), 256'(2'b10));
`else
    for (int j = 0; j < 40; j++) push(1'b0, 1'b0, '0, '0);
    a_i = ma; b_i = mb; start_i = 1'b1;
    tick(); start_i = 1'b0;
    for (int i = 0; i < 47; i++) tick();
    check("no_watchdog_busy", 256'({timeout_o, busy_o}), 256'(2'b01));
    flush_i = 1'b1;
    #6;
    tick(); flush_i = 1'b0;
`endif
    tick();
    check("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
